// File: rtl/addsub_arbiter.sv
// Round-robin front end sharing one external addsub datapath between two
// requesters; sequences IDLE -> EXEC -> RESP and counts overflowed results.
module addsub_arbiter #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_op,
   output logic [WIDTH-1:0] dp_a,
   output logic [WIDTH-1:0] dp_b,
   output logic             dp_addsub,
   input  logic [WIDTH-1:0] dp_s,
   input  logic             dp_cout,
   input  logic             dp_ov,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_s,
   output logic             rsp_cout,
   output logic             rsp_ov,
   output logic [CNT_W-1:0] ov_count,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic             r_last;
   logic             r_id;
   logic             r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_s;
   logic             r_cout;
   logic             r_ov;
   logic [CNT_W-1:0] r_cnt;
   logic             w_g0;
   logic             w_g1;
   logic             w_acc;
   logic             w_sat;

   // Tie goes to the requester that did not win last time.
   always_comb begin
      w_g0   = 1'b0;
      w_g1   = 1'b0;
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (!rst) begin
               if (req0_valid && (!req1_valid || r_last))
                  w_g0 = 1'b1;
               else if (req1_valid)
                  w_g1 = 1'b1;
            end
            if (w_g0 || w_g1)
               w_next = EXEC;
         end
         EXEC: w_next = RESP;
         RESP: begin
            if (rsp_ready)
               w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   assign w_acc = w_g0 | w_g1;
   assign w_sat = &r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
         r_id    <= 1'b0;
         r_op    <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
      end else begin
         r_state <= w_next;
         if (w_acc) begin
            r_a    <= w_g1 ? req1_a  : req0_a;
            r_b    <= w_g1 ? req1_b  : req0_b;
            r_op   <= w_g1 ? req1_op : req0_op;
            r_id   <= w_g1;
            r_last <= w_g1;
         end
      end
   end

   // Datapath result is only trusted while the operands are in EXEC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s    <= '0;
         r_cout <= 1'b0;
         r_ov   <= 1'b0;
         r_cnt  <= '0;
      end else if (r_state == EXEC) begin
         r_s    <= dp_s;
         r_cout <= dp_cout;
         r_ov   <= dp_ov;
         if (dp_ov && !w_sat)
            r_cnt <= r_cnt + 1'b1;
      end
   end

   assign req0_ready = w_g0;
   assign req1_ready = w_g1;
   assign dp_a       = r_a;
   assign dp_b       = r_b;
   assign dp_addsub  = r_op;
   assign rsp_valid  = (r_state == RESP);
   assign rsp_id     = r_id;
   assign rsp_s      = r_s;
   assign rsp_cout   = r_cout;
   assign rsp_ov     = r_ov;
   assign ov_count   = r_cnt;
   assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_addsub_arbiter.sv
// Randomized and directed bench for addsub_arbiter against a
// transaction-level reference model with an in-bench datapath.
`timescale 1ns/1ps
module tb_addsub_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0_valid = 1'b0;
   logic       req0_ready;
   logic [7:0] req0_a = '0;
   logic [7:0] req0_b = '0;
   logic       req0_op = 1'b0;
   logic       req1_valid = 1'b0;
   logic       req1_ready;
   logic [7:0] req1_a = '0;
   logic [7:0] req1_b = '0;
   logic       req1_op = 1'b0;
   logic [7:0] dp_a;
   logic [7:0] dp_b;
   logic       dp_addsub;
   logic [7:0] dp_s;
   logic       dp_cout;
   logic       dp_ov;
   logic       rsp_valid;
   logic       rsp_ready = 1'b1;
   logic       rsp_id;
   logic [7:0] rsp_s;
   logic       rsp_cout;
   logic       rsp_ov;
   logic [7:0] ov_count;
   logic       busy;

   addsub_arbiter #(.WIDTH(8), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .dp_a(dp_a), .dp_b(dp_b), .dp_addsub(dp_addsub),
      .dp_s(dp_s), .dp_cout(dp_cout), .dp_ov(dp_ov),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_s(rsp_s),
      .rsp_cout(rsp_cout), .rsp_ov(rsp_ov),
      .ov_count(ov_count), .busy(busy)
   );

   always #5 clk = ~clk;

   // External addsub_8bit stand-in
   logic [7:0] w_bx;
   logic [8:0] w_sum;
   assign w_bx    = dp_b ^ {8{dp_addsub}};
   assign w_sum   = {1'b0, dp_a} + {1'b0, w_bx} + {8'd0, dp_addsub};
   assign dp_s    = w_sum[7:0];
   assign dp_cout = w_sum[8];
   assign dp_ov   = (dp_a[7] == w_bx[7]) && (w_sum[7] != dp_a[7]);

   typedef struct {
      logic       id;
      logic [7:0] a;
      logic [7:0] b;
      logic       op;
   } txn_t;

   txn_t q[$];
   bit   gnt_log[$];
   int   n_vec = 0;
   int   n_err = 0;
   bit   m_busy = 0;
   bit   m_wait = 0;
   bit   m_last = 1;
   int   m_cnt  = 0;
   bit   acc0, acc1;
   bit   keep0 = 0, keep1 = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void ref_calc(input logic [7:0] a, input logic [7:0] b,
                                    input logic op, output logic [7:0] s,
                                    output logic c, output logic v);
      int sa, sb, r;
      sa = $signed(a);
      sb = $signed(b);
      r  = op ? sa - sb : sa + sb;
      v  = (r > 127) || (r < -128);
      s  = r[7:0];
      c  = op ? (a >= b) : ((int'(a) + int'(b)) > 255);
   endfunction

   task automatic step();
      bit g0, g1, hs;
      logic [7:0] es;
      logic ec, ev;
      g0 = 0;
      g1 = 0;
      acc0 = 0;
      acc1 = 0;
      @(negedge clk);
      if (rst) begin
         chk("rst_rdy0", req0_ready, 0);
         chk("rst_rdy1", req1_ready, 0);
         chk("rst_rspv", rsp_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_cnt", ov_count, 0);
         chk("rst_dpa", dp_a, 0);
      end else begin
         g0 = !m_busy && req0_valid && (!req1_valid || m_last);
         g1 = !m_busy && req1_valid && (!req0_valid || !m_last);
         chk("rdy0", req0_ready, g0);
         chk("rdy1", req1_ready, g1);
         chk("rspv", rsp_valid, m_busy && !m_wait);
         chk("busy", busy, m_busy);
         chk("ovcnt", ov_count, m_cnt);
         if (m_busy) begin
            chk("dp_a", dp_a, q[0].a);
            chk("dp_b", dp_b, q[0].b);
            chk("dp_op", dp_addsub, q[0].op);
            if (!m_wait) begin
               ref_calc(q[0].a, q[0].b, q[0].op, es, ec, ev);
               chk("rsp_id", rsp_id, q[0].id);
               chk("rsp_s", rsp_s, es);
               chk("rsp_cout", rsp_cout, ec);
               chk("rsp_ov", rsp_ov, ev);
            end
         end
      end
      hs = rsp_ready;
      @(posedge clk);
      if (rst) begin
         m_busy = 0;
         m_wait = 0;
         m_last = 1;
         m_cnt  = 0;
         q.delete();
      end else if (m_busy) begin
         if (m_wait) begin
            m_wait = 0;
            ref_calc(q[0].a, q[0].b, q[0].op, es, ec, ev);
            if (ev && m_cnt < 255) m_cnt++;
         end else if (hs) begin
            m_busy = 0;
            void'(q.pop_front());
         end
      end else if (g0 || g1) begin
         if (g1) q.push_back('{1'b1, req1_a, req1_b, req1_op});
         else    q.push_back('{1'b0, req0_a, req0_b, req0_op});
         gnt_log.push_back(g1);
         m_busy = 1;
         m_wait = 1;
         m_last = g1;
         acc0 = g0;
         acc1 = g1;
      end
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         step();
         if (acc0 && !keep0) req0_valid = 0;
         if (acc1 && !keep1) req1_valid = 0;
      end
   endtask

   task automatic do_reset();
      rst = 1;
      req0_valid = 0;
      req1_valid = 0;
      keep0 = 0;
      keep1 = 0;
      rsp_ready = 1;
      step();
      step();
      rst = 0;
   endtask

   task automatic set0(input logic [7:0] a, input logic [7:0] b, input logic op);
      req0_a = a; req0_b = b; req0_op = op; req0_valid = 1;
   endtask

   task automatic set1(input logic [7:0] a, input logic [7:0] b, input logic op);
      req1_a = a; req1_b = b; req1_op = op; req1_valid = 1;
   endtask

   function automatic logic [7:0] rnd_op();
      logic [7:0] v;
      case ($urandom_range(0, 4))
         0: v = 8'h00;
         1: v = 8'h7F;
         2: v = 8'h80;
         3: v = 8'hFF;
         default: v = 8'($urandom);
      endcase
      return v;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] hold_s;
      // 1: single add from requester 0
      do_reset();
      set0(8'd7, 8'hFB, 0);
      run(2);
      chk("t1_rspv", rsp_valid, 1);
      chk("t1_id", rsp_id, 0);
      chk("t1_s", rsp_s, 8'd2);
      chk("t1_cout", rsp_cout, 1);
      chk("t1_ov", rsp_ov, 0);
      run(2);
      // 2: overflowing add then subtract
      set1(8'd8, 8'd124, 0);
      run(2);
      chk("t2_s", rsp_s, 8'h84);
      chk("t2_ov", rsp_ov, 1);
      run(2);
      chk("t2_cnt1", ov_count, 1);
      set0(8'd25, 8'd13, 1);
      run(2);
      chk("t2_sub", rsp_s, 8'd12);
      run(2);
      chk("t2_cnt2", ov_count, 1);
      // 3: both requesting continuously
      do_reset();
      gnt_log.delete();
      keep0 = 1;
      keep1 = 1;
      set0(8'd28, 8'h83, 1);
      set1(8'h81, 8'h81, 0);
      run(12);
      chk("t3_cnt", ov_count, 4);
      chk("t3_ngnt", gnt_log.size(), 4);
      for (int i = 0; i < gnt_log.size() && i < 4; i++)
         chk("t3_gnt", gnt_log[i], i % 2);
      keep0 = 0;
      keep1 = 0;
      req0_valid = 0;
      req1_valid = 0;
      run(3);
      // 4: back-pressure on the response
      set0(8'd100, 8'd50, 1);
      run(2);
      rsp_ready = 0;
      set1(8'd1, 8'd2, 0);
      hold_s = rsp_s;
      run(5);
      chk("t4_hold", rsp_s, hold_s);
      chk("t4_rdy1", req1_ready, 0);
      rsp_ready = 1;
      run(1);
      chk("t4_idle", busy, 0);
      run(1);
      chk("t4_take", busy, 1);
      chk("t4_dpa", dp_a, 8'd1);
      run(3);
      // 5: reset during EXEC
      do_reset();
      set1(8'd3, 8'd4, 0);
      run(1);
      chk("t5_exec", busy, 1);
      rst = 1;
      #1;
      chk("t5_busy", busy, 0);
      chk("t5_rspv", rsp_valid, 0);
      chk("t5_dpa", dp_a, 0);
      step();
      rst = 0;
      set0(8'd9, 8'd9, 0);
      set1(8'd5, 8'd5, 0);
      run(1);
      chk("t5_tie", dp_a, 8'd9);
      run(2);
      chk("t5_id", rsp_id, 0);
      run(6);
      // 6: counter saturation
      do_reset();
      keep0 = 1;
      set0(8'd128, 8'd128, 0);
      run(3 * 262);
      keep0 = 0;
      req0_valid = 0;
      run(3);
      chk("t6_sat", ov_count, 8'hFF);
      // Random traffic
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rsp_ready = ($urandom_range(0, 3) != 0);
         step();
         if (acc0) req0_valid = 0;
         if (acc1) req1_valid = 0;
         if (!req0_valid && $urandom_range(0, 2) == 0)
            set0(rnd_op(), rnd_op(), 1'($urandom));
         else if (req0_valid && !acc0 && $urandom_range(0, 15) == 0)
            req0_valid = 0;
         if (!req1_valid && $urandom_range(0, 2) == 0)
            set1(rnd_op(), rnd_op(), 1'($urandom));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one combinational addsub_8bit datapath between two requesters.
- Accepts operand/operation requests on two valid/ready channels, drives the datapath from registered operands, captures S/cout/ov_flag, and returns the result on a shared response channel tagged with the requester ID.
- Keeps a saturating count of overflowed operations for debug readout.
- Sits between client logic and the addsub_8bit instance, which is external to this block.

Parameters:
- WIDTH, 8, operand/result width; must match the datapath.
- CNT_W, 8, width of the overflow event counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req0_a  in  WIDTH  requester 0 operand A.
- req0_b  in  WIDTH  requester 0 operand B.
- req0_op  in  1  requester 0 operation; 0 = A+B, 1 = A−B.
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as above, for requester 1.
- dp_a  out  WIDTH  to datapath A.
- dp_b  out  WIDTH  to datapath B.
- dp_addsub  out  1  to datapath addsub.
- dp_s  in  WIDTH  from datapath S.
- dp_cout  in  1  from datapath cout.
- dp_ov  in  1  from datapath ov_flag.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_id  out  1  requester that owns the result.
- rsp_s  out  WIDTH  registered result.
- rsp_cout  out  1  registered carry.
- rsp_ov  out  1  registered overflow.
- ov_count  out  CNT_W  saturating count of completed ops with ov=1.
- busy  out  1  state != IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values (asynchronous): all outputs 0; last_grant = 1, so requester 0 wins the first tie.
- IDLE:
  - If only reqN_valid is high, reqN_ready = 1.
  - If both are high, grant the requester != last_grant.
  - reqN_ready is combinational, asserted only in IDLE, and never asserted for both requesters at once.
  - On an accept edge: latch a, b, op into the operand registers, set id and last_grant to the granted requester, then go to EXEC.
- EXEC (exactly 1 cycle):
  - dp_a/dp_b/dp_addsub come from the operand registers and stay stable for the whole cycle.
  - At the edge: capture dp_s/dp_cout/dp_ov into rsp_s/rsp_cout/rsp_ov.
  - If dp_ov = 1, increment ov_count, saturating at 2^CNT_W−1 with no wrap.
  - Go to RESP.
- RESP:
  - rsp_valid = 1. rsp_id/rsp_s/rsp_cout/rsp_ov are held stable until the handshake.
  - rsp_valid & rsp_ready at an edge: go to IDLE.
  - While rsp_ready is low, stay in RESP indefinitely. No new request is accepted.
- Latency and throughput:
  - Accept edge → rsp_valid high 2 cycles later.
  - Minimum 3 cycles per operation.
  - Returning to IDLE with a request pending gives ready in that same IDLE cycle.
- Datapath outputs: dp_* hold their last operands outside EXEC. The datapath result is sampled only in EXEC.
- Requester contract: a requester must hold valid and operands until ready. Dropping valid before ready is legal; nothing is latched.
- Arithmetic: the block does not compute. Results are passed through unmodified, with the datapath's two's-complement rules (cout = raw carry out of A + (B^op) + op).
- Reset mid-operation: rst in EXEC or RESP aborts immediately to IDLE. The in-flight result is lost, ov_count clears, and rsp_valid drops asynchronously.

Test Plan:
1. Reset, then req0: a=8'd7, b=8'hFB, op=0 → req0_ready in the same cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_s=8'd2, rsp_cout=1, rsp_ov=0.
2. req1: a=8'd8, b=8'd124, op=0 → rsp_s=8'h84, cout=0, ov=1, ov_count=1. Then req0: a=8'd25, b=8'd13, op=1 → rsp_s=8'd12, cout=1, ov=0, ov_count unchanged.
3. Both valid continuously after reset (req0: 28−(−125); req1: −127+−127) → grants alternate 0,1,0,1. Responses: rsp_s=8'h99/cout 0/ov 1 and rsp_s=8'h02/cout 1/ov 1. ov_count increments every op.
4. Hold rsp_ready=0 for 5 cycles in RESP with req1_valid high → rsp_* stable, req1_ready stays 0. Raise rsp_ready → IDLE on the next edge, and req1 is accepted in that IDLE cycle.
5. Assert rst during EXEC → outputs 0 immediately; no rsp_valid follows. The next request is granted to requester 0 on a tie.
6. Force 2^CNT_W+3 overflow ops (use 8'd128+8'd128) → ov_count saturates at 8'hFF.
